// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue controller: issues way0, way0+way1 or nothing to Ex, tracking pending
// long-latency writes in a register scoreboard. Optional perf counters under SCHED_PERF_CNT_EN.
module dual_issue_scheduler #(
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              way0_valid_i,
  input  logic [ADDR_W-1:0] way0_rs1Addr_i,
  input  logic [ADDR_W-1:0] way0_rs2Addr_i,
  input  logic              way0_rs1ReadEnable_i,
  input  logic              way0_rs2ReadEnable_i,
  input  logic [ADDR_W-1:0] way0_rdAddr_i,
  input  logic              way0_rdWriteEnable_i,
  input  logic              way0_longLat_i,
  input  logic              way0_serialize_i,
  input  logic              way1_valid_i,
  input  logic [ADDR_W-1:0] way1_rs1Addr_i,
  input  logic [ADDR_W-1:0] way1_rs2Addr_i,
  input  logic              way1_rs1ReadEnable_i,
  input  logic              way1_rs2ReadEnable_i,
  input  logic [ADDR_W-1:0] way1_rdAddr_i,
  input  logic              way1_rdWriteEnable_i,
  input  logic              way1_longLat_i,
  input  logic              way1_serialize_i,
  input  logic              ex_ready_i,
  input  logic              flush_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_rdAddr_i,
`ifdef SCHED_PERF_CNT_EN
  output logic [31:0]       stallHazard_o,
  output logic [31:0]       dualIssue_o,
`endif
  output logic              way0_issue_o,
  output logic              way1_issue_o,
  output logic [NREG-1:0]   busy_o
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state, state_next;
  logic [NREG-1:0]   busy, busy_next, set_vec, clr_vec;
  logic              busy_any;
  logic              w0_wr, w1_wr, w0_hz, w1_hz, pair_dep, w0_ok, w1_ok;

  // Register x0 is hardwired, so it never carries a hazard.
  function automatic logic hazard(input logic [ADDR_W-1:0] r, input logic [NREG-1:0] b);
    return (r != '0) && b[r];
  endfunction

  assign busy_any = |busy;
  assign busy_o   = busy;

  always_comb begin
    w0_wr = (way0_rdWriteEnable_i || way0_longLat_i) && (way0_rdAddr_i != '0);
    w1_wr = (way1_rdWriteEnable_i || way1_longLat_i) && (way1_rdAddr_i != '0);

    w0_hz = (way0_rs1ReadEnable_i && hazard(way0_rs1Addr_i, busy)) ||
            (way0_rs2ReadEnable_i && hazard(way0_rs2Addr_i, busy)) ||
            (w0_wr && hazard(way0_rdAddr_i, busy));
    w1_hz = (way1_rs1ReadEnable_i && hazard(way1_rs1Addr_i, busy)) ||
            (way1_rs2ReadEnable_i && hazard(way1_rs2Addr_i, busy)) ||
            (w1_wr && hazard(way1_rdAddr_i, busy));

    pair_dep = w0_wr && ((way1_rs1ReadEnable_i && (way1_rs1Addr_i == way0_rdAddr_i)) ||
                         (way1_rs2ReadEnable_i && (way1_rs2Addr_i == way0_rdAddr_i)) ||
                         (w1_wr && (way1_rdAddr_i == way0_rdAddr_i)));

    w0_ok = way0_valid_i && ex_ready_i && !flush_i && !w0_hz &&
            (!way0_serialize_i || !busy_any);

    way0_issue_o = !rst && (state == RUN) && w0_ok;

    w1_ok = way0_issue_o && way1_valid_i && !way0_serialize_i && !way1_serialize_i &&
            !w1_hz && !pair_dep && !(way0_longLat_i && way1_longLat_i);
    way1_issue_o = w1_ok;
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:   if (way0_valid_i && way0_serialize_i && busy_any && !flush_i) state_next = DRAIN;
      DRAIN: if (!busy_any || flush_i) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Set wins over a same-cycle clear of the same register.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (way0_issue_o && way0_longLat_i && (way0_rdAddr_i != '0)) set_vec[way0_rdAddr_i] = 1'b1;
    if (way1_issue_o && way1_longLat_i && (way1_rdAddr_i != '0)) set_vec[way1_rdAddr_i] = 1'b1;
    if (wb_valid_i && (wb_rdAddr_i != '0)) clr_vec[wb_rdAddr_i] = 1'b1;
    busy_next = (busy & ~clr_vec) | set_vec;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      busy  <= '0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallHazard_o <= '0;
      dualIssue_o   <= '0;
    end else begin
      if (way0_valid_i && ex_ready_i && !way0_issue_o && (stallHazard_o != '1))
        stallHazard_o <= stallHazard_o + 32'd1;
      if (way1_issue_o && (dualIssue_o != '1))
        dualIssue_o <= dualIssue_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard-style bench for dual_issue_scheduler: expectations are queued as stimulus is
// applied, DUT observations queued at sample time, and each scenario task compares the pairs.
module tb_dual_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        way0_valid_i, way0_rs1ReadEnable_i, way0_rs2ReadEnable_i;
  logic        way0_rdWriteEnable_i, way0_longLat_i, way0_serialize_i;
  logic [4:0]  way0_rs1Addr_i, way0_rs2Addr_i, way0_rdAddr_i;
  logic        way1_valid_i, way1_rs1ReadEnable_i, way1_rs2ReadEnable_i;
  logic        way1_rdWriteEnable_i, way1_longLat_i, way1_serialize_i;
  logic [4:0]  way1_rs1Addr_i, way1_rs2Addr_i, way1_rdAddr_i;
  logic        ex_ready_i, flush_i, wb_valid_i;
  logic [4:0]  wb_rdAddr_i;
  logic        way0_issue_o, way1_issue_o;
  logic [31:0] busy_o;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stallHazard_o, dualIssue_o;
`endif

  typedef struct packed {
    logic        w0;
    logic        w1;
    logic [31:0] busy;
  } obs_t;

  obs_t  exp_q[$];
  obs_t  obs_q[$];
  string nm_q[$];
  int    passed = 0;
  int    total  = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler dut (
    .clk(clk), .rst(rst),
    .way0_valid_i(way0_valid_i), .way0_rs1Addr_i(way0_rs1Addr_i), .way0_rs2Addr_i(way0_rs2Addr_i),
    .way0_rs1ReadEnable_i(way0_rs1ReadEnable_i), .way0_rs2ReadEnable_i(way0_rs2ReadEnable_i),
    .way0_rdAddr_i(way0_rdAddr_i), .way0_rdWriteEnable_i(way0_rdWriteEnable_i),
    .way0_longLat_i(way0_longLat_i), .way0_serialize_i(way0_serialize_i),
    .way1_valid_i(way1_valid_i), .way1_rs1Addr_i(way1_rs1Addr_i), .way1_rs2Addr_i(way1_rs2Addr_i),
    .way1_rs1ReadEnable_i(way1_rs1ReadEnable_i), .way1_rs2ReadEnable_i(way1_rs2ReadEnable_i),
    .way1_rdAddr_i(way1_rdAddr_i), .way1_rdWriteEnable_i(way1_rdWriteEnable_i),
    .way1_longLat_i(way1_longLat_i), .way1_serialize_i(way1_serialize_i),
    .ex_ready_i(ex_ready_i), .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rdAddr_i(wb_rdAddr_i),
`ifdef SCHED_PERF_CNT_EN
    .stallHazard_o(stallHazard_o), .dualIssue_o(dualIssue_o),
`endif
    .way0_issue_o(way0_issue_o), .way1_issue_o(way1_issue_o), .busy_o(busy_o)
  );

  // v, rs1, re1, rs2, re2, rd, we, longLat, serialize
  task automatic set_w0(input logic v, input logic [4:0] rs1, input logic re1, input logic [4:0] rs2,
                        input logic re2, input logic [4:0] rd, input logic we, input logic ll,
                        input logic ser);
    way0_valid_i = v; way0_rs1Addr_i = rs1; way0_rs1ReadEnable_i = re1;
    way0_rs2Addr_i = rs2; way0_rs2ReadEnable_i = re2; way0_rdAddr_i = rd;
    way0_rdWriteEnable_i = we; way0_longLat_i = ll; way0_serialize_i = ser;
  endtask

  task automatic set_w1(input logic v, input logic [4:0] rs1, input logic re1, input logic [4:0] rs2,
                        input logic re2, input logic [4:0] rd, input logic we, input logic ll,
                        input logic ser);
    way1_valid_i = v; way1_rs1Addr_i = rs1; way1_rs1ReadEnable_i = re1;
    way1_rs2Addr_i = rs2; way1_rs2ReadEnable_i = re2; way1_rdAddr_i = rd;
    way1_rdWriteEnable_i = we; way1_longLat_i = ll; way1_serialize_i = ser;
  endtask

  task automatic idle();
    set_w0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_w1(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_ready_i = 1'b1; flush_i = 1'b0; wb_valid_i = 1'b0; wb_rdAddr_i = '0;
  endtask

  // Queue the expected outputs for the stimulus now applied, then record what the DUT shows.
  task automatic expect_now(input string nm, input logic e0, input logic e1, input logic [31:0] eb);
    exp_q.push_back('{w0: e0, w1: e1, busy: eb});
    nm_q.push_back(nm);
    #2;
    obs_q.push_back('{w0: way0_issue_o, w1: way1_issue_o, busy: busy_o});
  endtask

  task automatic test_reset();
    obs_t e, o; string nm;
    rst = 1'b1; idle();
    set_w0(1, 1, 1, 2, 1, 3, 1, 0, 0);
    set_w1(1, 4, 1, 5, 1, 6, 1, 0, 0);
    @(negedge clk); expect_now("reset", 0, 0, 32'h0);
    @(negedge clk); rst = 1'b0; idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); total += 3;
      if (o.w0 !== e.w0) $display("FAIL %s way0_issue got %b want %b", nm, o.w0, e.w0); else passed++;
      if (o.w1 !== e.w1) $display("FAIL %s way1_issue got %b want %b", nm, o.w1, e.w1); else passed++;
      if (o.busy !== e.busy) $display("FAIL %s busy got %h want %h", nm, o.busy, e.busy); else passed++;
    end
  endtask

  task automatic test_independent();
    obs_t e, o; string nm;
    @(negedge clk); idle();
    set_w0(1, 1, 1, 2, 1, 3, 1, 0, 0); set_w1(1, 4, 1, 5, 1, 6, 1, 0, 0);
    expect_now("indep_pair", 1, 1, 32'h0);
    @(negedge clk); ex_ready_i = 1'b0;
    expect_now("ex_not_ready", 0, 0, 32'h0);
    @(negedge clk); ex_ready_i = 1'b1; flush_i = 1'b1;
    expect_now("flush_block", 0, 0, 32'h0);
    @(negedge clk); idle(); set_w1(1, 4, 1, 5, 1, 6, 1, 0, 0);
    expect_now("way1_without_way0", 0, 0, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); total += 3;
      if (o.w0 !== e.w0) $display("FAIL %s way0_issue got %b want %b", nm, o.w0, e.w0); else passed++;
      if (o.w1 !== e.w1) $display("FAIL %s way1_issue got %b want %b", nm, o.w1, e.w1); else passed++;
      if (o.busy !== e.busy) $display("FAIL %s busy got %h want %h", nm, o.busy, e.busy); else passed++;
    end
  endtask

  task automatic test_intra_pair();
    obs_t e, o; string nm;
    @(negedge clk); idle();
    set_w0(1, 1, 1, 2, 1, 5, 1, 0, 0); set_w1(1, 5, 1, 4, 1, 6, 1, 0, 0);
    expect_now("raw_pair", 1, 0, 32'h0);
    @(negedge clk); idle(); set_w0(1, 5, 1, 4, 1, 6, 1, 0, 0);
    expect_now("raw_moved_to_way0", 1, 0, 32'h0);
    @(negedge clk); idle();
    set_w0(1, 1, 1, 0, 0, 5, 1, 0, 0); set_w1(1, 2, 1, 0, 0, 5, 1, 0, 0);
    expect_now("waw_pair", 1, 0, 32'h0);
    @(negedge clk); idle();
    set_w0(1, 1, 1, 0, 0, 3, 0, 1, 0); set_w1(1, 2, 1, 0, 0, 4, 0, 1, 0);
    expect_now("two_longlat", 1, 0, 32'h0);
    @(negedge clk); idle();
    expect_now("longlat_set", 0, 0, 32'h8);
    @(negedge clk); wb_valid_i = 1'b1; wb_rdAddr_i = 5'd3;
    expect_now("wb_no_bypass", 0, 0, 32'h8);
    @(negedge clk); idle();
    set_w0(1, 1, 1, 2, 1, 3, 1, 0, 0); set_w1(1, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_now("way1_serialize", 1, 0, 32'h0);
    @(negedge clk); idle();
    set_w0(1, 1, 1, 0, 0, 0, 1, 0, 0); set_w1(1, 0, 1, 0, 1, 7, 1, 0, 0);
    expect_now("x0_no_dep", 1, 1, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); total += 3;
      if (o.w0 !== e.w0) $display("FAIL %s way0_issue got %b want %b", nm, o.w0, e.w0); else passed++;
      if (o.w1 !== e.w1) $display("FAIL %s way1_issue got %b want %b", nm, o.w1, e.w1); else passed++;
      if (o.busy !== e.busy) $display("FAIL %s busy got %h want %h", nm, o.busy, e.busy); else passed++;
    end
  endtask

  task automatic test_load_use();
    obs_t e, o; string nm;
    @(negedge clk); idle();
    set_w0(1, 1, 1, 0, 0, 7, 0, 1, 0); set_w1(1, 7, 1, 0, 0, 8, 1, 0, 0);
    expect_now("load_issue", 1, 0, 32'h0);
    @(negedge clk); idle(); set_w0(1, 7, 1, 0, 0, 8, 1, 0, 0);
    expect_now("load_use_stall", 0, 0, 32'h80);
    @(negedge clk); wb_valid_i = 1'b1; wb_rdAddr_i = 5'd7;
    expect_now("load_use_wb", 0, 0, 32'h80);
    @(negedge clk); wb_valid_i = 1'b0; wb_rdAddr_i = '0;
    expect_now("load_use_go", 1, 0, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); total += 3;
      if (o.w0 !== e.w0) $display("FAIL %s way0_issue got %b want %b", nm, o.w0, e.w0); else passed++;
      if (o.w1 !== e.w1) $display("FAIL %s way1_issue got %b want %b", nm, o.w1, e.w1); else passed++;
      if (o.busy !== e.busy) $display("FAIL %s busy got %h want %h", nm, o.busy, e.busy); else passed++;
    end
  endtask

  task automatic test_serialize_drain();
    obs_t e, o; string nm;
    @(negedge clk); idle(); set_w0(1, 1, 1, 0, 0, 10, 0, 1, 0);
    expect_now("drain_load_x10", 1, 0, 32'h0);
    @(negedge clk); idle(); set_w0(1, 12, 1, 0, 0, 11, 1, 0, 1);
    expect_now("drain_enter", 0, 0, 32'h400);
    @(negedge clk); wb_valid_i = 1'b1; wb_rdAddr_i = 5'd10;
    expect_now("drain_wb", 0, 0, 32'h400);
    @(negedge clk); wb_valid_i = 1'b0; wb_rdAddr_i = '0;
    expect_now("drain_empty", 0, 0, 32'h0);
    @(negedge clk); set_w1(1, 4, 1, 5, 1, 6, 1, 0, 0);
    expect_now("csr_alone", 1, 0, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); total += 3;
      if (o.w0 !== e.w0) $display("FAIL %s way0_issue got %b want %b", nm, o.w0, e.w0); else passed++;
      if (o.w1 !== e.w1) $display("FAIL %s way1_issue got %b want %b", nm, o.w1, e.w1); else passed++;
      if (o.busy !== e.busy) $display("FAIL %s busy got %h want %h", nm, o.busy, e.busy); else passed++;
    end
  endtask

  task automatic test_set_clear();
    obs_t e, o; string nm;
    @(negedge clk); idle(); set_w0(1, 1, 1, 0, 0, 9, 0, 1, 0);
    wb_valid_i = 1'b1; wb_rdAddr_i = 5'd9;
    expect_now("set_clear_same", 1, 0, 32'h0);
    @(negedge clk); idle(); set_w0(1, 0, 0, 0, 0, 9, 1, 0, 0);
    expect_now("set_wins_waw", 0, 0, 32'h200);
    @(negedge clk); idle(); wb_valid_i = 1'b1; wb_rdAddr_i = 5'd9;
    expect_now("clear_x9", 0, 0, 32'h200);
    @(negedge clk); idle(); set_w0(1, 0, 0, 0, 0, 0, 1, 1, 0);
    expect_now("load_x0", 1, 0, 32'h0);
    @(negedge clk); idle();
    expect_now("x0_never_busy", 0, 0, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); total += 3;
      if (o.w0 !== e.w0) $display("FAIL %s way0_issue got %b want %b", nm, o.w0, e.w0); else passed++;
      if (o.w1 !== e.w1) $display("FAIL %s way1_issue got %b want %b", nm, o.w1, e.w1); else passed++;
      if (o.busy !== e.busy) $display("FAIL %s busy got %h want %h", nm, o.busy, e.busy); else passed++;
    end
  endtask

  task automatic test_flush_drain();
    obs_t e, o; string nm;
    @(negedge clk); idle(); set_w0(1, 1, 1, 0, 0, 10, 0, 1, 0);
    expect_now("fd_load_x10", 1, 0, 32'h0);
    @(negedge clk); idle(); set_w0(1, 12, 1, 0, 0, 11, 1, 0, 1);
    expect_now("fd_enter_drain", 0, 0, 32'h400);
    @(negedge clk); flush_i = 1'b1;
    expect_now("fd_flush", 0, 0, 32'h400);
    @(negedge clk); idle();
    set_w0(1, 1, 1, 2, 1, 3, 1, 0, 0); set_w1(1, 4, 1, 5, 1, 6, 1, 0, 0);
    expect_now("fd_back_in_run", 1, 1, 32'h400);
    @(negedge clk); idle(); wb_valid_i = 1'b1; wb_rdAddr_i = 5'd10;
    expect_now("fd_wb", 0, 0, 32'h400);
    @(negedge clk); idle();
    expect_now("fd_clean", 0, 0, 32'h0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); total += 3;
      if (o.w0 !== e.w0) $display("FAIL %s way0_issue got %b want %b", nm, o.w0, e.w0); else passed++;
      if (o.w1 !== e.w1) $display("FAIL %s way1_issue got %b want %b", nm, o.w1, e.w1); else passed++;
      if (o.busy !== e.busy) $display("FAIL %s busy got %h want %h", nm, o.busy, e.busy); else passed++;
    end
  endtask

  task automatic test_reset_mid_drain();
    obs_t e, o; string nm;
    logic [31:0] model = '0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); idle(); set_w0(1, 0, 0, 0, 0, 5'(i), 0, 1, 0);
      expect_now($sformatf("fill_x%0d", i), 1, 0, model);
      model[i] = 1'b1;
    end
    @(negedge clk); idle();
    expect_now("fill_done", 0, 0, 32'hFFFF_FFFE);
    @(negedge clk); set_w0(1, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_now("full_drain", 0, 0, 32'hFFFF_FFFE);
    @(negedge clk); idle(); rst = 1'b1;
    set_w0(1, 1, 1, 2, 1, 3, 1, 0, 0); set_w1(1, 4, 1, 5, 1, 6, 1, 0, 0);
    expect_now("rst_mid_drain", 0, 0, 32'h0);
    @(negedge clk); rst = 1'b0;
    expect_now("run_after_rst", 1, 1, 32'h0);
    @(negedge clk); idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = nm_q.pop_front(); total += 3;
      if (o.w0 !== e.w0) $display("FAIL %s way0_issue got %b want %b", nm, o.w0, e.w0); else passed++;
      if (o.w1 !== e.w1) $display("FAIL %s way1_issue got %b want %b", nm, o.w1, e.w1); else passed++;
      if (o.busy !== e.busy) $display("FAIL %s busy got %h want %h", nm, o.busy, e.busy); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_intra_pair();
    test_load_use();
    test_serialize_drain();
    test_set_clear();
    test_flush_drain();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
